// File: rtl/uart_pkg.sv
//==============================================================================
// Module   : uart_pkg
// Purpose  : Shared frame constants, FSM state types and baud divisor helper.
// Revision : 1.0
//==============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_e;

    // Rounded clocks-per-bit.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
//==============================================================================
// Module   : uart_rx
// Purpose  : 8N1 receiver with 2-flop input synchronizer and stop-bit check.
// Revision : 1.0
//==============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV = 1250
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_fresh
);

    localparam int               CNT_W     = $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 fresh_q, fresh_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            fresh_q <= 1'b0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            fresh_q <= fresh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        fresh_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = RX_START;
            end
            // Half-bit recheck rejects glitches and centres all later samples.
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) state_d = RX_STOP;
                    else                   bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        data_d  = shift_q;
                        fresh_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_WAIT: begin
                if (sync2_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_data       = data_q;
    assign rx_data_fresh = fresh_q;

endmodule

`default_nettype wire

// File: rtl/uart_core.sv
//==============================================================================
// Module   : uart_core
// Purpose  : Full-duplex 8N1 UART, valid/ack transmit and pulsed receive.
//            Define UART_RX_EN to build the receiver; otherwise TX only.
// Revision : 1.0
//==============================================================================
`default_nettype none

module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 9600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_data_valid,
    output logic                 tx_data_ack,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_fresh
);

    localparam int               DIV      = calc_div(CLK_HZ, BAUD);
    localparam int               CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

    tx_state_e          tx_state_q, tx_state_d;
    logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS:0] shift_q, shift_d;
    logic               txd_q, txd_d;
    logic               run_q, run_d;
    logic               frame_end;
    logic               accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            run_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            run_q      <= run_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        txd_d      = txd_q;
        run_d      = 1'b1;

        frame_end = (tx_state_q == TX_SEND) && (div_cnt_q == DIV_LAST)
                    && (bit_cnt_q == BIT_LAST);
        // Accepting in the last stop-bit cycle keeps streamed frames gap-free.
        accept    = run_q && tx_data_valid
                    && ((tx_state_q == TX_IDLE) || frame_end);

        case (tx_state_q)
            TX_IDLE: ;
            TX_SEND: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        tx_state_d = TX_IDLE;
                        txd_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (accept) begin
            tx_state_d = TX_SEND;
            shift_d    = {1'b1, tx_data};
            txd_d      = 1'b0;
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
        end
    end

    assign tx_data_ack = accept;
    assign txd         = txd_q;

`ifdef UART_RX_EN
    uart_rx #(
        .DIV(DIV)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_data_fresh(rx_data_fresh)
    );
`else
    assign rx_data       = '0;
    // rxd is given a (constant-zero) load so the unused pin stays lint-clean.
    assign rx_data_fresh = 1'b0 & rxd;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_core.sv
//==============================================================================
// Module   : tb_uart_core
// Purpose  : Directed self-checking bench for uart_core (DIV = 13 build).
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_core;

    localparam int CLK_HZ = 120_000;
    localparam int BAUD   = 9600;
    localparam int DIV    = 13;        // (120000 + 4800) / 9600
    localparam int HALF   = DIV / 2;
    localparam int LIMIT  = 20 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       tx_data_ack;
    logic       txd;
    logic       rxd_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_data_fresh;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fresh_cnt = 0;
    int ack_seen = 0;
    logic [9:0] dec_q[$];
    logic [7:0] stream_b [3] = '{8'h00, 8'hFF, 8'h3C};

    assign rxd = loop_en ? txd : rxd_drv;

    uart_core #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ack  (tx_data_ack),
        .txd          (txd),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_data_fresh(rx_data_fresh)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rx_data_fresh === 1'b1) fresh_cnt <= fresh_cnt + 1;

    // Reference line decoder: stores {stop, data, start} per frame seen on txd.
    initial begin
        logic [9:0] f;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (HALF) @(negedge clk);
                f[0] = txd;
                for (int i = 1; i < 10; i++) begin
                    repeat (DIV) @(negedge clk);
                    f[i] = txd;
                end
                dec_q.push_back(f);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            if (tx_data_ack === 1'b1) ack_seen++;
        end
    endtask

    task automatic wait_ack(output int n);
        int t;
        t = 0;
        while (tx_data_ack !== 1'b1 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        chk("ack_wait", 32'(t < LIMIT), 32'd1);
        n = cyc;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd_drv = f[k];
            repeat (DIV) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (3 * DIV) @(negedge clk);
    endtask

    initial begin
        int n0, n1, f0;
        int ack_cyc [3];
        logic [9:0] exp_f;

        repeat (3) @(negedge clk);
        chk("rst_txd",   txd,           1);
        chk("rst_ack",   tx_data_ack,   0);
        chk("rst_rxdat", rx_data,       8'h00);
        chk("rst_fresh", rx_data_fresh, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_txd", txd, 1);
        chk("idle_ack", tx_data_ack, 0);

        // Single byte with valid held high: exact bit edges and ack spacing.
        tx_data = 8'hA5;
        tx_data_valid = 1'b1;
        #1;
        wait_ack(n0);
        ack_seen = 0;
        exp_f = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            goto(n0 + 1 + k * DIV);
            chk("a5_bit_first", txd, exp_f[k]);
            if (k == 9) begin
                goto(n0 + 10 * DIV - 1);
                chk("a5_no_dup_ack", ack_seen, 0);
            end
            goto(n0 + (k + 1) * DIV);
            chk("a5_bit_last", txd, exp_f[k]);
        end
        chk("a5_next_ack", tx_data_ack, 1);
        @(negedge clk);
        tx_data_valid = 1'b0;
        goto(n0 + 20 * DIV + 5);
        chk("a5_frames", dec_q.size(), 2);
        while (dec_q.size() > 0) chk("a5_decoded", dec_q.pop_front(), exp_f);

        // Streaming: valid dropped for one cycle after each ack.
        for (int i = 0; i < 3; i++) begin
            tx_data = stream_b[i];
            tx_data_valid = 1'b1;
            #1;
            wait_ack(n1);
            ack_cyc[i] = n1;
            @(negedge clk);
            tx_data_valid = 1'b0;
            @(negedge clk);
        end
        chk("stream_gap01", ack_cyc[1] - ack_cyc[0], 10 * DIV);
        chk("stream_gap12", ack_cyc[2] - ack_cyc[1], 10 * DIV);
        goto(ack_cyc[2] + 10 * DIV + 5);
        chk("stream_frames", dec_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (dec_q.size() > 0) chk("stream_byte", dec_q.pop_front(), {1'b1, stream_b[i], 1'b0});
        end

`ifdef UART_RX_EN
        f0 = fresh_cnt;
        send_rx(8'h5A, 1'b1);
        chk("rx5a_pulses", fresh_cnt - f0, 1);
        chk("rx5a_data",   rx_data, 8'h5A);

        // Low shorter than half a bit is rejected as a false start.
        f0 = fresh_cnt;
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        chk("glitch_pulses", fresh_cnt - f0, 0);

        f0 = fresh_cnt;
        send_rx(8'h77, 1'b0);
        chk("ferr_pulses", fresh_cnt - f0, 0);
        chk("ferr_hold",   rx_data, 8'h5A);

        f0 = fresh_cnt;
        send_rx(8'hC3, 1'b1);
        chk("rxc3_pulses", fresh_cnt - f0, 1);
        chk("rxc3_data",   rx_data, 8'hC3);
`endif

        // Loopback through txd.
        loop_en = 1'b1;
        repeat (2) @(negedge clk);
        f0 = fresh_cnt;
        tx_data = 8'h81;
        tx_data_valid = 1'b1;
        #1;
        wait_ack(n1);
        @(negedge clk);
        tx_data_valid = 1'b0;
        goto(n1 + 10 * DIV + 10);
`ifdef UART_RX_EN
        chk("loop_pulses", fresh_cnt - f0, 1);
        chk("loop_data",   rx_data, 8'h81);
`else
        chk("loop_no_fresh", fresh_cnt, 0);
        chk("loop_rx_zero",  rx_data, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_core.md
# uart_core

Full-duplex 8N1 UART transceiver with a byte-wide valid/ack transmit interface and a pulse-qualified receive interface. Bit timing comes from a single clock divided down to the configured baud rate. It sits between board-level serial pins and the system logic that streams data, such as memory dump logic that pushes one SRAM byte per acknowledged transfer.

## Interface
- CLK_HZ, default 12_000_000: input clock frequency in Hz.
- BAUD, default 9600: line rate in bits per second. The ratio CLK_HZ/BAUD must be at least 4.
- clk, input, 1: the single clock. Everything is synchronous to its rising edge.
- rst, input, 1: reset, asynchronous and active-low.
- tx_data, input, 8: byte to transmit. Sampled only on the cycle tx_data_ack is high.
- tx_data_valid, input, 1: tx_data holds a byte to send.
- tx_data_ack, output, 1: one-cycle pulse; the byte has been accepted.
- txd, output, 1: serial transmit line. Idle level is high.
- rxd, input, 1: serial receive line, asynchronous to clk.
- rx_data, output, 8: last correctly framed received byte.
- rx_data_fresh, output, 1: one-cycle pulse; rx_data has just been updated.

## Operation
- Divisor DIV = (CLK_HZ + BAUD/2) / BAUD, computed at elaboration. The defaults give DIV = 1250.
- Frame format: one start bit (0), 8 data bits sent LSB first, one stop bit (1). There is no parity.
- Transmitter has two states, TX_IDLE and TX_SEND.
  - In TX_IDLE with tx_data_valid high: pulse tx_data_ack for that cycle, latch tx_data into a shift register, and go to TX_SEND.
  - In TX_SEND the transmitter shifts out 10 bits of DIV cycles each, then returns to TX_IDLE.
  - tx_data_valid is ignored while in TX_SEND. Holding valid high after an ack therefore does not duplicate a byte; the next byte is accepted only after the current stop bit ends.
- Receiver has states RX_IDLE, RX_START, RX_DATA, RX_STOP and RX_WAIT.
  - rxd passes through a 2-flop synchronizer before use.
  - RX_IDLE: a synchronized low moves to RX_START.
  - RX_START: re-check the line at DIV/2. If it is high, treat it as a false start and return to RX_IDLE.
  - RX_DATA: sample each data bit DIV cycles after the previous sample, i.e. at bit centre.
  - RX_STOP: sample the stop bit at its centre. If it is 1, load rx_data and pulse rx_data_fresh, then go to RX_IDLE. If it is 0 (framing error), discard the byte, leave rx_data unchanged, and go to RX_WAIT.
  - RX_WAIT: stay until the line reads high, then go to RX_IDLE.
- Transmitter and receiver operate fully independently.

## Timing
- Reset values: txd=1, tx_data_ack=0, rx_data=8'h00, rx_data_fresh=0. Both state machines go to idle and all counters clear.
- Asserting rst mid-frame aborts the frame immediately and txd returns high.
- TX latency: ack in cycle N, txd goes low at N+1, and stays low for DIV cycles.
- TX frame length is 10*DIV cycles. The earliest next ack is at cycle N + 10*DIV.
- Per-bit timing: each bit, stop bit included, holds for exactly DIV cycles.
- RX: rx_data_fresh rises 2 to 3 cycles after the stop-bit centre sample, because of synchronizer delay plus the registered output. rx_data is valid on that same cycle and holds until the next good frame.
- Wrap-around: the bit counter and divider counter reload to 0 at each terminal count. There is no accumulated error beyond DIV rounding.

## Configuration
- UART_RX_EN
  - Defined: the receiver is built as described above.
  - Undefined: no receive logic is built. rx_data is tied to 8'h00, rx_data_fresh to 0, and rxd is ignored. The transmitter is unchanged.

## Structure
- Shared package uart_pkg holds:
  - the tx and rx state enum typedefs;
  - the function that computes DIV from CLK_HZ and BAUD;
  - the constants DATA_BITS=8 and FRAME_BITS=10.
- The natural split is one sub-module, uart_rx, which holds the receiver, synchronizer and framing check. It is instantiated only under UART_RX_EN.
- The transmitter stays inline in uart_core.

## Test plan
- Reset: hold rst low -> txd=1, tx_data_ack=0, rx_data=00, rx_data_fresh=0. Release with valid low -> txd stays 1.
- Single TX byte: tx_data=8'hA5 with valid held high -> exactly one ack pulse. Then txd shows bits 0,1,0,1,0,0,1,0,1,1, each 1250 cycles long. The next ack comes 12500 cycles after the first.
- Streaming TX: drop valid on ack and reassert it the next cycle with a new byte -> frames are back-to-back with no idle gap and no duplicated or lost bytes across 3 bytes (00, FF, 3C).
- RX good frame: drive 8'h5A at 9600 baud on rxd -> one rx_data_fresh pulse with rx_data=5A.
- RX errors:
  - a 300-cycle low glitch -> no fresh pulse;
  - a frame carrying 8'h77 with stop bit 0 -> no fresh pulse, rx_data keeps its previous value, and the receiver recovers to accept a following good 8'hC3.
- Loopback with rxd tied to txd: transmitting 8'h81 -> rx_data_fresh with rx_data=81.
- UART_RX_EN undefined: the loopback case gives rx_data_fresh constantly 0.
